// File: rtl/shape_pkg.sv
// Shared types for the voice scheduler: oscillator wave shapes, the per-voice
// configuration word and the scheduler FSM state encoding.
package shape_pkg;

  localparam int AMP_W = 24;

  typedef enum logic [1:0] {
    SINE     = 2'd0,
    SQUARE   = 2'd1,
    SAWTOOTH = 2'd2,
    TRIANGLE = 2'd3
  } wave_shape;

  typedef struct packed {
    logic             enable;
    logic [15:0]      freq;
    logic [AMP_W-1:0] amplitude;
    wave_shape        shape;
  } voice_cfg_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SCAN   = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_ACCUM  = 3'd4,
    ST_OUTPUT = 3'd5
  } sched_state_e;

endpackage

// File: rtl/voice_scheduler_if.sv
// Configuration-write and shared-oscillator bus of the voice scheduler.
// The scheduler sits on the slave modport; the environment drives the master side.
interface voice_scheduler_if import shape_pkg::*; #(
  parameter int N_VOICES = 8,
  parameter int WIDTH    = 24
) ();

  localparam int IDX_W = $clog2(N_VOICES);

  logic                    cfg_valid;
  logic                    cfg_ready;
  logic [IDX_W-1:0]        cfg_voice;
  voice_cfg_t              cfg_data;

  logic                    osc_start;
  logic [15:0]             osc_freq;
  logic [WIDTH-1:0]        osc_amplitude;
  wave_shape               osc_shape;
  logic                    osc_done;
  logic signed [WIDTH-1:0] osc_out;

  modport slave (
    input  cfg_valid, cfg_voice, cfg_data, osc_done, osc_out,
    output cfg_ready, osc_start, osc_freq, osc_amplitude, osc_shape
  );

  modport master (
    output cfg_valid, cfg_voice, cfg_data, osc_done, osc_out,
    input  cfg_ready, osc_start, osc_freq, osc_amplitude, osc_shape
  );

endinterface

// File: rtl/voice_cfg_regs.sv
// Per-voice configuration register file: one synchronous write port and one
// combinational read port.
module voice_cfg_regs import shape_pkg::*; #(
  parameter  int N_VOICES = 8,
  localparam int IDX_W    = $clog2(N_VOICES)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  voice_cfg_t       i_wr_data,
  input  logic [IDX_W-1:0] i_rd_idx,
  output voice_cfg_t       o_rd_data
);

  voice_cfg_t r_cfg [N_VOICES];

  // NOTE: this file is small flops, not RAM, so it is reset; every voice must
  // come up disabled or a stale enable would trigger oscillator requests.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N_VOICES; i++) r_cfg[i] <= '0;
    end else if (i_we) begin
      r_cfg[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_rd_data = r_cfg[i_rd_idx];

endmodule

// File: rtl/voice_scheduler.sv
// Time-multiplexes one oscillator across N_VOICES voices: each sample_tick scans
// the enabled voices in index order and emits their saturated sum on mix_out.
module voice_scheduler import shape_pkg::*; #(
  parameter int N_VOICES = 8,
  parameter int WIDTH    = 24,
  parameter int TIMEOUT  = 255
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               sample_tick,
  voice_scheduler_if.slave   bus,
  output logic [WIDTH-1:0]   mix_out,
  output logic               mix_valid,
  output logic               busy,
  output logic               overrun,
  output logic               timeout
);

  localparam int IDX_W = $clog2(N_VOICES);
  localparam int ACC_W = WIDTH + IDX_W;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(N_VOICES - 1);
  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX  = {{(IDX_W + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN  = {{(IDX_W + 1){1'b1}}, {(WIDTH - 1){1'b0}}};

  sched_state_e            r_state;
  logic [IDX_W-1:0]        r_idx;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [WIDTH-1:0] r_sample;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_osc_start;
  logic [15:0]             r_osc_freq;
  logic [WIDTH-1:0]        r_osc_amp;
  wave_shape               r_osc_shape;
  logic [WIDTH-1:0]        r_mix_out;
  logic                    r_mix_valid;
  logic                    r_overrun;
  logic                    r_timeout;

  voice_cfg_t              w_rd_cfg;
  logic signed [ACC_W-1:0] w_acc_sum;
  logic signed [ACC_W-1:0] w_acc_final;
  logic [WIDTH-1:0]        w_sat;

  voice_cfg_regs #(.N_VOICES(N_VOICES)) u_cfg_regs (
    .clk       (clk),
    .rstn      (rstn),
    .i_we      (bus.cfg_valid & bus.cfg_ready),
    .i_wr_idx  (bus.cfg_voice),
    .i_wr_data (bus.cfg_data),
    .i_rd_idx  (r_idx),
    .o_rd_data (w_rd_cfg)
  );

  assign w_acc_sum = r_acc + {{IDX_W{r_sample[WIDTH-1]}}, r_sample};

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and infers a latch.
  always_comb begin
    w_acc_final = r_acc;
    if (r_state == ST_ACCUM) w_acc_final = w_acc_sum;
    w_sat = w_acc_final[WIDTH-1:0];
    if (w_acc_final > SAT_MAX)      w_sat = SAT_MAX[WIDTH-1:0];
    else if (w_acc_final < SAT_MIN) w_sat = SAT_MIN[WIDTH-1:0];
  end

  // NOTE: all state is written with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_acc       <= '0;
      r_sample    <= '0;
      r_cnt       <= '0;
      r_osc_start <= 1'b0;
      r_osc_freq  <= '0;
      r_osc_amp   <= '0;
      r_osc_shape <= SINE;
      r_mix_out   <= '0;
      r_mix_valid <= 1'b0;
      r_overrun   <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_osc_start <= 1'b0;
      r_mix_valid <= 1'b0;
      if (sample_tick && (r_state != ST_IDLE)) r_overrun <= 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (sample_tick) begin
            r_acc   <= '0;
            r_idx   <= '0;
            r_state <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          // Config is captured from the SCAN-cycle read, so a write landing in
          // this same cycle only shows up on the next frame.
          if (w_rd_cfg.enable) begin
            r_osc_freq  <= w_rd_cfg.freq;
            r_osc_amp   <= WIDTH'(w_rd_cfg.amplitude);
            r_osc_shape <= w_rd_cfg.shape;
            r_osc_start <= 1'b1;
            r_state     <= ST_ISSUE;
          end else if (r_idx == LAST_IDX) begin
            r_mix_out   <= w_sat;
            r_mix_valid <= 1'b1;
            r_state     <= ST_OUTPUT;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        ST_ISSUE: begin
          r_cnt   <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.osc_done) begin
            r_sample <= bus.osc_out;
            r_state  <= ST_ACCUM;
          end else if (r_cnt == CNT_LAST) begin
            r_sample  <= '0;
            r_timeout <= 1'b1;
            r_state   <= ST_ACCUM;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_ACCUM: begin
          r_acc <= w_acc_sum;
          if (r_idx == LAST_IDX) begin
            r_mix_out   <= w_sat;
            r_mix_valid <= 1'b1;
            r_state     <= ST_OUTPUT;
          end else begin
            r_idx   <= r_idx + 1'b1;
            r_state <= ST_SCAN;
          end
        end
        ST_OUTPUT: r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.cfg_ready     = rstn;
  assign bus.osc_start     = r_osc_start;
  assign bus.osc_freq      = r_osc_freq;
  assign bus.osc_amplitude = r_osc_amp;
  assign bus.osc_shape     = r_osc_shape;
  assign mix_out           = r_mix_out;
  assign mix_valid         = r_mix_valid;
  assign busy              = (r_state != ST_IDLE);
  assign overrun           = r_overrun;
  assign timeout           = r_timeout;

endmodule
